instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Initiator side of the instruction-memory read interface: owns the PC, drives a word-aligned
//  byte address to the combinational instruction memory each cycle, captures the returned word
//  and forwards {pc, instr} to decode through a small fetch queue with a valid/ready handshake.
//  Handles branch/jump redirect (flush), halt requests and fetch faults. Sits between the
//  instruction memory and the decode stage of the single-issue RV32 core.
// PARAMETERS
//  XLEN          32   datapath/address width
//  RESET_VECTOR  0    byte address of first fetch after reset
//  MEM_WORDS     256  instruction memory depth in 32-bit words; legal PC < MEM_WORDS*4
//  QUEUE_DEPTH   2    fetch queue entries (power of 2, >=2)
// PORTS
//  clk              in   1     single clock, rising edge
//  rst_n            in   1     asynchronous, active-low reset
//  imem_address     out  XLEN  byte address to instruction memory (= pc, bits[1:0]=0)
//  imem_instruction in   32    word returned combinationally for imem_address
//  redirect_valid   in   1     branch/jump taken this cycle
//  redirect_target  in   XLEN  new PC (byte address)
//  halt_req         in   1     stop fetching (level, sampled each cycle)
//  if_valid         out  1     queue head valid toward decode
//  if_ready         in   1     decode accepts head this cycle
//  if_instr         out  32    instruction at queue head
//  if_pc            out  XLEN  PC of instruction at queue head
//  fetch_fault      out  1     sticky: misaligned redirect or PC out of range
//  halted           out  1     FSM in HALTED
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_VECTOR, queue empty, if_valid=0, fetch_fault=0, halted=0,
//   state=BOOT. if_instr/if_pc=0 while empty.
//  FSM: BOOT -> RUN after exactly one clock with rst_n=1 (no fetch in BOOT).
//   RUN -> HALTED on halt_req=1, or on fault. HALTED is terminal; only reset exits.
//  Fetch (RUN): fetch_en = !full || pop. If fetch_en and pc legal: push {pc, imem_instruction},
//   pc <= pc+4 (mod 2^XLEN). Throughput 1 instr/cycle; push-to-if_valid latency 1 cycle.
//  Pop: if_valid && if_ready. Push and pop in same cycle when full: allowed, count unchanged.
//  Redirect (any state except HALTED, highest priority): queue flushed (incl. same-cycle push
//   and pop: head not consumed), pc <= redirect_target; next cycle fetches target.
//   If redirect_target[1:0]!=0: no pc update, fetch_fault<=1, state<=HALTED, queue flushed.
//   Redirect in BOOT: pc updated, BOOT->RUN still after one cycle.
//  Out of range: in RUN, pc >= MEM_WORDS*4 at a fetch attempt -> no push, fetch_fault<=1,
//   HALTED. Entries already queued still drain to decode.
//  halt_req (no redirect): no push that cycle, HALTED next; queued entries drain; pc frozen.
//  Priority same cycle: misaligned redirect > redirect > halt_req > fetch.
//  imem_address = pc at all times (also in BOOT/HALTED); memory read has no side effects.
//  Handshake: if_instr/if_pc stable while if_valid=1 and if_ready=0 (unless redirect flush).
// STRUCTURE
//  Shared include riscv_defs.vh: XLEN, fetch FSM state encodings (BOOT/RUN/HALTED),
//   INSTR_BYTES=4, RESET_VECTOR default.
//  Sub-module fetch_queue: synchronous FIFO, width 32+XLEN, QUEUE_DEPTH entries,
//   push/pop/flush, full/empty, wrap-around pointers with count. Top holds PC + FSM.
// TESTING
//  1 Reset release, imem word[i]=i+100, if_ready=1 -> BOOT 1 cycle; if_pc=0,4,8.. on
//    consecutive cycles with if_instr=100,101,102.
//  2 if_ready=0 for 5 cycles -> exactly 2 entries queued (pc 0,4), pc holds at 8,
//    if_pc stays 0; release -> 0,4,8 in order, no loss/duplication.
//  3 redirect_valid with target 0x40 while queue full -> next if_valid=0, then if_pc=0x40,
//    0x44; entries pc 0/4 never delivered.
//  4 redirect_target=0x42 -> fetch_fault=1, halted=1, if_valid=0, pc unchanged; stays so
//    until rst_n pulse, which restores pc=0, fault=0.
//  5 MEM_WORDS=4, run from 0 -> pcs 0,4,8,12 delivered, then fetch_fault=1, halted=1.
//  6 halt_req with 2 queued, if_ready=1 -> both drain, halted=1, no further pushes;
//    async rst_n mid-stream clears queue and outputs immediately.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-unit constants and the fetch FSM state encoding.
package instruction_fetch_unit_pkg;

    localparam int unsigned DEFAULT_XLEN = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [DEFAULT_XLEN-1:0] DEFAULT_RESET_VECTOR = '0;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StHalted
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read port plus the fetch-to-decode valid/ready channel.
interface instruction_fetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] imem_address;
    logic [31:0]     imem_instruction;
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;

    modport master (
        output imem_address,
        input  imem_instruction,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc
    );

    modport slave (
        input  imem_address,
        output imem_instruction,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc
    );
endinterface

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Small synchronous FIFO with flush; head reads as zero while empty.
module instruction_fetch_unit_fetch_queue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  rptr_q, wptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CntW'(DEPTH));
    // Flush wins over both push and pop issued in the same cycle.
    assign do_push  = push && !flush && (!full || pop);
    assign do_pop   = pop && !flush && !empty;
    assign pop_data = empty ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop) rptr_q <= rptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns PC and boot/run/halt FSM, reads imem and queues {pc, instr} for decode.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned      XLEN         = DEFAULT_XLEN,
    parameter logic [XLEN-1:0]  RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int unsigned      MEM_WORDS    = 256,
    parameter int unsigned      QUEUE_DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instruction_fetch_unit_if.master  bus,
    input  logic                      redirect_valid,
    input  logic [XLEN-1:0]           redirect_target,
    input  logic                      halt_req,
    output logic                      fetch_fault,
    output logic                      halted
);
    localparam int unsigned     EntryW  = 32 + XLEN;
    localparam logic [XLEN:0]   PcLimit = (XLEN + 1)'(MEM_WORDS) << 2;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;
    logic            push, pop, flush, full, empty, fetch_en, pc_legal;
    logic [EntryW-1:0] head;

    assign pc_legal = ({1'b0, pc_q} < PcLimit);
    assign pop      = !empty && bus.if_ready;
    assign fetch_en = !full || pop;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (state_q != StHalted && redirect_valid) begin
            flush = 1'b1;
            if (redirect_target[1:0] != 2'b00) begin
                fault_d = 1'b1;
                state_d = StHalted;
            end else begin
                pc_d = redirect_target;
                if (state_q == StBoot) state_d = StRun;
            end
        end else begin
            unique case (state_q)
                StBoot: state_d = StRun;
                StRun: begin
                    if (halt_req) begin
                        state_d = StHalted;
                    end else if (fetch_en) begin
                        if (pc_legal) begin
                            push = 1'b1;
                            pc_d = pc_q + XLEN'(INSTR_BYTES);
                        end else begin
                            fault_d = 1'b1;
                            state_d = StHalted;
                        end
                    end
                end
                StHalted: state_d = StHalted;
                default:  state_d = StHalted;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StBoot;
            pc_q    <= RESET_VECTOR;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    instruction_fetch_unit_fetch_queue #(
        .WIDTH(EntryW),
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data({pc_q, bus.imem_instruction}),
        .pop      (pop),
        .flush    (flush),
        .pop_data (head),
        .full     (full),
        .empty    (empty)
    );

    assign bus.imem_address = pc_q;
    assign bus.if_valid     = !empty;
    assign bus.if_pc        = head[EntryW-1:32];
    assign bus.if_instr     = head[31:0];
    assign fetch_fault      = fault_q;
    assign halted           = (state_q == StHalted);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a randomized stream.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        halt_req = 1'b0;
    logic        fault, halted, fault2, halted2;
    logic [31:0] mem [256];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit_if #(.XLEN(32)) bus ();
    instruction_fetch_unit_if #(.XLEN(32)) bus2 ();

    assign bus.imem_instruction  = (bus.imem_address < 32'd1024) ?
                                   mem[bus.imem_address[9:2]] : 32'hbad00bad;
    assign bus2.imem_instruction = (bus2.imem_address < 32'd1024) ?
                                   mem[bus2.imem_address[9:2]] : 32'hbad00bad;
    assign bus2.if_ready = 1'b1;

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.master),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .halt_req       (halt_req),
        .fetch_fault    (fault),
        .halted         (halted)
    );

    instruction_fetch_unit #(.MEM_WORDS(4)) dut_small (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus2.master),
        .redirect_valid (1'b0),
        .redirect_target(32'h0),
        .halt_req       (1'b0),
        .fetch_fault    (fault2),
        .halted         (halted2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem_linear();
        for (int i = 0; i < 256; i++) mem[i] = 32'(i + 100);
    endtask

    // Leaves rst_n released just after an edge; the next edge is the single BOOT cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        halt_req = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        fill_mem_linear();
        bus.if_ready = 1'b1;
        rst_n = 1'b0;
        step();
        checks++; if (bus.if_valid !== 1'b0) begin failures++;
            $display("FAIL reset_valid got=%0b exp=0", bus.if_valid); end
        checks++; if (bus.if_pc !== 32'h0 || bus.if_instr !== 32'h0) begin failures++;
            $display("FAIL reset_head got=%h/%h exp=0/0", bus.if_pc, bus.if_instr); end
        checks++; if (fault !== 1'b0 || halted !== 1'b0) begin failures++;
            $display("FAIL reset_flags got=%0b%0b exp=00", fault, halted); end
        checks++; if (bus.imem_address !== 32'h0) begin failures++;
            $display("FAIL reset_addr got=%h exp=0", bus.imem_address); end
    endtask

    task automatic test_sequential();
        fill_mem_linear();
        do_reset();
        bus.if_ready = 1'b1;
        step();
        checks++; if (bus.if_valid !== 1'b0) begin failures++;
            $display("FAIL boot_no_fetch got=%0b exp=0", bus.if_valid); end
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(4 * k) ||
                bus.if_instr !== 32'(100 + k)) begin
                failures++;
                $display("FAIL seq_stream k=%0d got=%0b/%h/%0d exp=1/%h/%0d", k, bus.if_valid,
                         bus.if_pc, bus.if_instr, 4 * k, 100 + k);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        fill_mem_linear();
        do_reset();
        bus.if_ready = 1'b0;
        step();
        for (int k = 0; k < 5; k++) step();
        checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== 32'd100)
            begin failures++;
            $display("FAIL bp_hold got=%0b/%h/%0d exp=1/0/100", bus.if_valid, bus.if_pc,
                     bus.if_instr); end
        checks++; if (bus.imem_address !== 32'h8) begin failures++;
            $display("FAIL bp_pc_hold got=%h exp=8", bus.imem_address); end
        bus.if_ready = 1'b1;
        exp_pc = 32'h0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== exp_pc) begin
                failures++;
                $display("FAIL bp_drain k=%0d got=%0b/%h exp=1/%h", k, bus.if_valid, bus.if_pc,
                         exp_pc);
            end
            exp_pc += 32'd4;
            step();
        end
    endtask

    task automatic test_redirect();
        fill_mem_linear();
        do_reset();
        bus.if_ready = 1'b0;
        step();
        step();
        step();
        checks++; if (bus.if_pc !== 32'h0 || bus.imem_address !== 32'h8) begin failures++;
            $display("FAIL redir_pre got=%h/%h exp=0/8", bus.if_pc, bus.imem_address); end
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        bus.if_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        checks++; if (bus.if_valid !== 1'b0 || bus.imem_address !== 32'h40) begin failures++;
            $display("FAIL redir_flush got=%0b/%h exp=0/40", bus.if_valid, bus.imem_address); end
        step();
        checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h40 || bus.if_instr !== 32'd116)
            begin failures++;
            $display("FAIL redir_first got=%0b/%h/%0d exp=1/40/116", bus.if_valid, bus.if_pc,
                     bus.if_instr); end
        step();
        checks++; if (bus.if_pc !== 32'h44 || bus.if_instr !== 32'd117) begin failures++;
            $display("FAIL redir_second got=%h/%0d exp=44/117", bus.if_pc, bus.if_instr); end
    endtask

    task automatic test_misaligned();
        fill_mem_linear();
        do_reset();
        bus.if_ready = 1'b1;
        step();
        step();
        step();
        step();
        checks++; if (bus.imem_address !== 32'd12) begin failures++;
            $display("FAIL mis_pre got=%h exp=c", bus.imem_address); end
        redirect_valid = 1'b1;
        redirect_target = 32'h42;
        step();
        checks++; if (fault !== 1'b1 || halted !== 1'b1 || bus.if_valid !== 1'b0 ||
                      bus.imem_address !== 32'd12) begin failures++;
            $display("FAIL mis_fault got=%0b%0b%0b/%h exp=110/c", fault, halted, bus.if_valid,
                     bus.imem_address); end
        redirect_target = 32'h80;
        for (int k = 0; k < 4; k++) step();
        redirect_valid = 1'b0;
        checks++; if (fault !== 1'b1 || halted !== 1'b1 || bus.if_valid !== 1'b0 ||
                      bus.imem_address !== 32'd12) begin failures++;
            $display("FAIL mis_sticky got=%0b%0b%0b/%h exp=110/c", fault, halted, bus.if_valid,
                     bus.imem_address); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (fault !== 1'b0 || halted !== 1'b0 || bus.imem_address !== 32'h0) begin
            failures++;
            $display("FAIL mis_reset got=%0b%0b/%h exp=00/0", fault, halted, bus.imem_address);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] got_pc[$];
        logic [31:0] got_instr[$];
        fill_mem_linear();
        do_reset();
        step();
        for (int k = 0; k < 10; k++) begin
            if (bus2.if_valid) begin
                got_pc.push_back(bus2.if_pc);
                got_instr.push_back(bus2.if_instr);
            end
            step();
        end
        checks++; if (got_pc.size() != 4) begin failures++;
            $display("FAIL oor_count got=%0d exp=4", got_pc.size()); end
        for (int k = 0; k < got_pc.size() && k < 4; k++) begin
            checks++;
            if (got_pc[k] !== 32'(4 * k) || got_instr[k] !== 32'(100 + k)) begin
                failures++;
                $display("FAIL oor_entry k=%0d got=%h/%0d exp=%h/%0d", k, got_pc[k],
                         got_instr[k], 4 * k, 100 + k);
            end
        end
        checks++; if (fault2 !== 1'b1 || halted2 !== 1'b1 || bus2.if_valid !== 1'b0) begin
            failures++;
            $display("FAIL oor_fault got=%0b%0b%0b exp=110", fault2, halted2, bus2.if_valid);
        end
    endtask

    task automatic test_halt();
        logic [31:0] got_pc[$];
        fill_mem_linear();
        do_reset();
        bus.if_ready = 1'b0;
        step();
        step();
        step();
        halt_req = 1'b1;
        bus.if_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (bus.if_valid) got_pc.push_back(bus.if_pc);
            step();
        end
        halt_req = 1'b0;
        checks++; if (got_pc.size() != 2) begin failures++;
            $display("FAIL halt_count got=%0d exp=2", got_pc.size()); end
        else begin
            checks++; if (got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4) begin failures++;
                $display("FAIL halt_order got=%h,%h exp=0,4", got_pc[0], got_pc[1]); end
        end
        checks++; if (halted !== 1'b1 || fault !== 1'b0 || bus.if_valid !== 1'b0 ||
                      bus.imem_address !== 32'h8) begin failures++;
            $display("FAIL halt_state got=%0b%0b%0b/%h exp=100/8", halted, fault, bus.if_valid,
                     bus.imem_address); end
        do_reset();
        bus.if_ready = 1'b0;
        step();
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.if_valid !== 1'b0 || bus.if_pc !== 32'h0 || bus.if_instr !== 32'h0 ||
                      bus.imem_address !== 32'h0) begin failures++;
            $display("FAIL async_reset got=%0b/%h/%h/%h exp=0/0/0/0", bus.if_valid, bus.if_pc,
                     bus.if_instr, bus.imem_address); end
    endtask

    // Transaction-level model: decode must see consecutive PCs starting at the last redirect.
    task automatic test_random_stream();
        logic [31:0] exp_pc, held_pc, held_instr;
        logic        hold, redir;
        int          delivered;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        do_reset();
        bus.if_ready = 1'b0;
        step();
        exp_pc = 32'h0;
        hold = 1'b0;
        held_pc = 32'h0;
        held_instr = 32'h0;
        delivered = 0;
        for (int c = 0; c < 150; c++) begin
            if (hold) begin
                checks++;
                if (bus.if_valid !== 1'b1 || bus.if_pc !== held_pc || bus.if_instr !== held_instr)
                begin
                    failures++;
                    $display("FAIL rnd_stable c=%0d got=%0b/%h/%h exp=1/%h/%h", c, bus.if_valid,
                             bus.if_pc, bus.if_instr, held_pc, held_instr);
                end
            end
            bus.if_ready = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 15) == 0);
            redirect_valid = redir;
            redirect_target = redir ? 32'($urandom_range(0, 63)) << 2 : 32'h0;
            if (redir) begin
                exp_pc = redirect_target;
            end else if (bus.if_valid && bus.if_ready) begin
                checks++;
                if (bus.if_pc !== exp_pc || bus.if_instr !== mem[exp_pc[9:2]]) begin
                    failures++;
                    $display("FAIL rnd_stream c=%0d got=%h/%h exp=%h/%h", c, bus.if_pc,
                             bus.if_instr, exp_pc, mem[exp_pc[9:2]]);
                end
                exp_pc += 32'd4;
                delivered++;
            end
            hold = !redir && bus.if_valid && !bus.if_ready;
            held_pc = bus.if_pc;
            held_instr = bus.if_instr;
            step();
        end
        redirect_valid = 1'b0;
        checks++; if (delivered < 40) begin failures++;
            $display("FAIL rnd_throughput got=%0d exp>=40", delivered); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.if_ready = 1'b0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_out_of_range();
        test_halt();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
